// File: rtl/bit_count_sequencer.sv
// Bit-count sequencer: scans N_WORDS bytes from a synchronous-read memory,
// hands each byte to a bit-count responder over the s/data/result/done
// handshake, and reports the total set bits, the largest per-word count
// and the address of the first word reaching it.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   go             level start request (scan restarts only after go drops)
//   rd_addr        memory read address (1-cycle read latency)
//   rd_data        memory read data
//   s, data        start and byte under test to the responder
//   result, done   responder count (0..8) and completion
//   total          sum of all results
//   max_count      largest result seen
//   max_addr       address of the first word achieving max_count
//   finished       scan complete
//   error          responder timeout occurred
module bit_count_sequencer #(
   parameter int ADDR_W  = 5,
   parameter int N_WORDS = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              s,
   output logic [7:0]        data,
   input  logic [3:0]        result,
   input  logic              done,
   output logic [ADDR_W+3:0] total,
   output logic [3:0]        max_count,
   output logic [ADDR_W-1:0] max_addr,
   output logic              finished,
   output logic              error
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_WORDS - 1);
   // The counter is checked before incrementing, so the TIMEOUT-th waiting
   // cycle is the one where it reads TIMEOUT-1.
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SETUP,
      ASSERT,
      RELEASE,
      FIN
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] idx, idx_nxt;
   logic [TW-1:0]     tmr, tmr_nxt;
   logic [7:0]        data_nxt;
   logic [ADDR_W+3:0] total_nxt;
   logic [3:0]        max_nxt;
   logic [ADDR_W-1:0] maxa_nxt;
   logic              err_nxt;

   // Handshake outputs decode straight from the state register, so any
   // transition out of ASSERT (including reset) drops s on that edge.
   assign s        = (state == ASSERT);
   assign finished = (state == FIN);
   assign rd_addr  = (state == IDLE) ? '0 : idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         tmr       <= '0;
         data      <= '0;
         total     <= '0;
         max_count <= '0;
         max_addr  <= '0;
         error     <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         tmr       <= tmr_nxt;
         data      <= data_nxt;
         total     <= total_nxt;
         max_count <= max_nxt;
         max_addr  <= maxa_nxt;
         error     <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      tmr_nxt   = tmr;
      data_nxt  = data;
      total_nxt = total;
      max_nxt   = max_count;
      maxa_nxt  = max_addr;
      err_nxt   = error;
      unique case (state)
         IDLE: begin
            if (go) begin
               total_nxt = '0;
               max_nxt   = '0;
               maxa_nxt  = '0;
               err_nxt   = 1'b0;
               idx_nxt   = '0;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            state_nxt = LOAD;
         end
         LOAD: begin
            data_nxt  = rd_data;
            state_nxt = SETUP;
         end
         SETUP: begin
            // Responder latches data while s is low; hold it one cycle.
            tmr_nxt   = '0;
            state_nxt = ASSERT;
         end
         ASSERT: begin
            if (done) begin
               total_nxt = total + {{ADDR_W{1'b0}}, result};
               if (result > max_count) begin
                  max_nxt  = result;
                  maxa_nxt = idx;
               end
               tmr_nxt   = '0;
               state_nxt = RELEASE;
            end else if (tmr == TLIM) begin
               err_nxt   = 1'b1;
               state_nxt = FIN;
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         RELEASE: begin
            if (!done) begin
               tmr_nxt = '0;
               if (idx == LAST) begin
                  state_nxt = FIN;
               end else begin
                  idx_nxt   = idx + 1'b1;
                  state_nxt = FETCH;
               end
            end else if (tmr == TLIM) begin
               err_nxt   = 1'b1;
               state_nxt = FIN;
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         FIN: begin
            if (!go) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bit_count_sequencer.sv
// Randomized bench for bit_count_sequencer: memory model, randomized-delay
// responder, protocol checks and a set-bit reference model.
module tb_bit_count_sequencer;

   localparam int AW = 5;
   localparam int NW = 32;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          go;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          s;
   logic [7:0]    data;
   logic [3:0]    result;
   logic          done;
   logic [AW+3:0] total;
   logic [3:0]    max_count;
   logic [AW-1:0] max_addr;
   logic          finished;
   logic          error;

   logic [7:0] mem [NW];
   logic       nodone = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   bit_count_sequencer #(
      .ADDR_W (AW),
      .N_WORDS(NW),
      .TIMEOUT(TO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .go       (go),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .s        (s),
      .data     (data),
      .result   (result),
      .done     (done),
      .total    (total),
      .max_count(max_count),
      .max_addr (max_addr),
      .finished (finished),
      .error    (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= mem[rd_addr];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Responder with random done-rise and done-fall delays.
   int rs = 0;
   int dly = 0;
   always @(posedge clk) begin
      if (reset) begin
         done   <= 1'b0;
         result <= '0;
         rs     <= 0;
      end else begin
         case (rs)
            0: if (s) begin
                  dly <= int'($urandom_range(0, 4));
                  rs  <= 1;
               end
            1: if (dly == 0) begin
                  done   <= !nodone;
                  result <= 4'($countones(data));
                  rs     <= 2;
               end else dly <= dly - 1;
            2: if (!s) begin
                  dly <= int'($urandom_range(0, 4));
                  rs  <= 3;
               end
            3: if (dly == 0) begin
                  done <= 1'b0;
                  rs   <= 0;
               end else dly <= dly - 1;
            default: rs <= 0;
         endcase
      end
   end

   // Expected results from the reference model.
   int exp_total, exp_max, exp_addr, exp_err, exp_pulses;
   int base = 0;
   logic cmp_en = 1'b0;

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Compare process: protocol and final-result checks.
   logic       ps = 1'b0;
   logic       pf = 1'b0;
   logic [7:0] pd = '0;
   int         rise_cyc = 0;
   int         pulses = 0;
   always @(negedge clk) begin
      if (!reset) begin
         if (s && !ps) begin
            chk("setup_hold", int'(data), int'(pd));
            if (pulses - base < NW)
               chk("word_data", int'(data), int'(mem[pulses - base]));
            pulses   <= pulses + 1;
            rise_cyc <= cyc;
         end
         if (s && ps) chk("data_stable", int'(data), int'(pd));
         if (!s && ps && nodone) chk("timeout_len", cyc - rise_cyc, TO);
         if (finished && !pf && cmp_en) begin
            chk("total", int'(total), exp_total);
            chk("max_count", int'(max_count), exp_max);
            chk("max_addr", int'(max_addr), exp_addr);
            chk("error", int'(error), exp_err);
         end
      end
      ps <= s;
      pd <= data;
      pf <= finished;
   end

   task automatic model();
      int t = 0;
      int m = 0;
      int a = 0;
      for (int i = 0; i < NW; i++) begin
         int c;
         c = $countones(mem[i]);
         t += c;
         if (c > m) begin
            m = c;
            a = i;
         end
      end
      if (nodone) begin
         t = 0;
         m = 0;
         a = 0;
      end
      exp_total  = t;
      exp_max    = m;
      exp_addr   = a;
      exp_err    = nodone ? 1 : 0;
      exp_pulses = nodone ? 1 : NW;
   endtask

   task automatic run(input bit hold, input bit chk_clr);
      bit ok = 1'b0;
      model();
      cmp_en = 1'b1;
      @(negedge clk);
      base = pulses;
      go   = 1'b1;
      if (chk_clr) begin
         @(negedge clk);
         chk("clr_total", int'(total), 0);
         chk("clr_error", int'(error), 0);
         chk("clr_max", int'(max_count), 0);
      end
      for (int k = 0; k < 6000; k++) begin
         @(negedge clk);
         if (finished) begin
            ok = 1'b1;
            break;
         end
      end
      chk("finish_seen", int'(ok), 1);
      chk("pulses", pulses - base, exp_pulses);
      if (!hold) begin
         go = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1;
      go    = 1'b0;
      for (int i = 0; i < NW; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s", int'(s), 0);
      chk("rst_total", int'(total), 0);
      chk("rst_fin", int'(finished), 0);
      chk("rst_err", int'(error), 0);
      chk("rst_addr", int'(rd_addr), 0);
      @(negedge clk);
      reset = 1'b0;

      // Single set word.
      mem[0] = 8'h5B;
      run(0, 0);
      chk("lit5_total", int'(total), 5);
      chk("lit5_max", int'(max_count), 5);
      chk("lit5_addr", int'(max_addr), 0);

      // Ties keep the first address.
      mem[0] = 8'h00;
      mem[1] = 8'hFF;
      mem[2] = 8'h0F;
      mem[3] = 8'hFF;
      run(0, 1);
      chk("lit20_total", int'(total), 20);
      chk("lit20_max", int'(max_count), 8);
      chk("lit20_addr", int'(max_addr), 1);

      // Full-scale sum.
      for (int i = 0; i < NW; i++) mem[i] = 8'hFF;
      run(0, 1);
      chk("lit256_total", int'(total), 256);
      chk("lit256_max", int'(max_count), 8);
      chk("lit256_addr", int'(max_addr), 0);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NW; i++) mem[i] = 8'($urandom);
         run(0, 1);
      end

      // Responder never completes; hold go through FIN.
      nodone = 1'b1;
      run(1, 1);
      chk("to_fin", int'(finished), 1);
      chk("to_err", int'(error), 1);
      begin
         int p0;
         p0 = pulses;
         repeat (20) begin
            @(negedge clk);
            chk("hold_fin", int'(finished), 1);
         end
         chk("hold_nofetch", pulses, p0);
      end
      go = 1'b0;
      @(posedge clk);
      #1;
      chk("drop_fin", int'(finished), 0);
      nodone = 1'b0;
      for (int i = 0; i < NW; i++) mem[i] = 8'($urandom);
      run(0, 1);

      // Reset while word 2 is in its handshake.
      for (int i = 0; i < NW; i++) mem[i] = 8'($urandom);
      @(negedge clk);
      base = pulses;
      go   = 1'b1;
      begin
         bit hit = 1'b0;
         for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (s && pulses - base == 3) begin
               hit = 1'b1;
               break;
            end
         end
         chk("reach_word2", int'(hit), 1);
      end
      reset = 1'b1;
      go    = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_s", int'(s), 0);
      chk("mid_total", int'(total), 0);
      chk("mid_max", int'(max_count), 0);
      chk("mid_maxa", int'(max_addr), 0);
      chk("mid_fin", int'(finished), 0);
      chk("mid_addr", int'(rd_addr), 0);
      chk("mid_data", int'(data), 0);
      @(negedge clk);
      reset = 1'b0;
      run(0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bit_count_sequencer.md
Name: bit_count_sequencer

Overview:
- Initiator for the s/data/result/done bit-count handshake; this block drives the start side of that protocol.
- Walks N_WORDS bytes out of a synchronous-read memory and presents each byte to a bit-count responder.
- Collects each result and reports the total set-bit count, the largest per-word count, and the address of that largest word.
- Sits between the word memory and the responder on the FPGA top level; go and finished connect to switches and LEDs.

Parameters:
- ADDR_W, 5, memory address width.
- N_WORDS, 32, words to scan (1..2**ADDR_W).
- TIMEOUT, 64, max cycles to wait on a done edge before flagging an error.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- go  input  1  level start request from the user.
- rd_addr  output  ADDR_W  memory read address; memory has 1-cycle read latency.
- rd_data  input  8  memory read data.
- s  output  1  start to the responder.
- data  output  8  byte under test to the responder.
- result  input  4  responder count (0..8).
- done  input  1  responder completion.
- total  output  ADDR_W+4  sum of all results.
- max_count  output  4  largest result seen.
- max_addr  output  ADDR_W  address of the first word achieving max_count.
- finished  output  1  scan complete.
- error  output  1  responder timeout occurred.

Behaviour:
- Reset values: all outputs are 0, the state is IDLE, and the index and timeout counter are 0. Reset takes priority in any state, including mid-handshake; s drops on the next edge.
- IDLE:
  - s=0 and rd_addr=0.
  - If go=1: clear total, max_count, max_addr, error and idx, then go to FETCH.
- FETCH:
  - rd_addr=idx.
  - Go to LOAD next cycle.
- LOAD:
  - data<=rd_data, which is valid this cycle.
  - Go to SETUP.
- SETUP:
  - s=0 and data stable.
  - This state exists because the responder latches data only while s is low, so data must be held for at least one full cycle with s=0 before s rises.
  - Go to ASSERT.
- ASSERT:
  - s=1. data must not change while s=1.
  - The timeout counter increments each cycle.
  - If done=1:
    - total<=total+result (zero-extended).
    - If result>max_count (strictly greater): max_count<=result and max_addr<=idx. Ties keep the earlier address.
    - Clear the timer and go to RELEASE.
  - Else, if the counter reaches TIMEOUT: error<=1, s<=0, go to FIN.
- RELEASE:
  - s=0 and wait for done=0, with the same timeout rule.
  - On done=0: if idx==N_WORDS-1 go to FIN; else idx<=idx+1 and go to FETCH.
- FIN:
  - finished=1. total, max_count, max_addr and error are held.
  - Go to IDLE only when go=0. Holding go high never restarts the scan.
  - In IDLE, finished<=0.
- go changes outside IDLE and FIN are ignored.
- Widths:
  - total cannot overflow: the maximum is 8*N_WORDS, which is at most 2**(ADDR_W+3).
  - idx has ADDR_W bits and never wraps because the stop test is on N_WORDS-1.
- Per-word latency: 4 cycles (FETCH, LOAD, SETUP, first ASSERT) + responder time + RELEASE cycles.
- result is sampled only in the cycle where ASSERT sees done=1.
- If done is already high on entry to ASSERT (a stale done), it is accepted. This cannot occur in normal operation because RELEASE guarantees done=0 first.

Test Plan:
- Single word (N_WORDS=1): mem[0]=8'b01011011, go=1 with a real responder attached. Required: data=0x5B is stable with s=0 for 1 cycle before s rises; total=5, max_count=5, max_addr=0, finished=1, error=0.
- Four words (N_WORDS=4): mem={0x00,0xFF,0x0F,0xFF}. Required: total=20, max_count=8, max_addr=1 (tie keeps the first), and exactly 4 s pulses.
- Full 32-word scan, all 0xFF. Required: total=256 with no overflow, max_count=8, max_addr=0.
- Stub responder never raises done, TIMEOUT=64. Required: s falls and error=1 at 64 cycles after s rose; finished=1; total=0.
- Hold go=1 through FIN. Required: finished stays 1 and no new FETCH occurs. Then go=0 gives IDLE next cycle with finished=0; go=1 again starts a fresh scan with counters cleared.
- Assert reset during ASSERT on word 2. Required: the next cycle has s=0, all outputs 0 and state IDLE. A subsequent go runs a correct full scan.
